// File: rtl/sha256_digest_reader.sv
// Readout side of the SHA-256 result interface: captures the digest on the rising edge of
// finished and steps through its bytes with debounced-free synchronized pushbuttons.
module sha256_digest_reader #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BYTES   = 32
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   finished,
    input  logic [8*NUM_BYTES-1:0] digest_in,
    input  logic                   Next,
    input  logic                   Clear,
    output logic [7:0]             byte_out,
    output logic [4:0]             byte_idx,
    output logic                   valid,
    output logic [7:0]             leds,
    output logic [6:0]             hexU,
    output logic [6:0]             hexL,
    output logic [6:0]             hexC,
    output logic [6:0]             hex1
);

    // state | meaning
    // IDLE  | nothing shown, waiting for a capture
    // SHOW  | captured digest displayed at byte_idx
    typedef enum logic {IDLE, SHOW} state_t;

    localparam int         DW   = 8 * NUM_BYTES;
    localparam logic [4:0] LAST = 5'(NUM_BYTES - 1);
    localparam logic [6:0] BLANK = 7'h7F;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] next_sync, clear_sync;
    logic                   next_hist, clear_hist;
    logic                   fin_q;
    logic [DW-1:0]          digest_q, digest_n;
    logic [4:0]             idx_n;
    logic [7:0]             byte_sel;
    logic                   next_press, clear_press, capture;
    int                     sel_lo;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Buttons are active-low, so synchronizers and history reset to "released".
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            next_sync  <= '1;
            clear_sync <= '1;
            next_hist  <= 1'b1;
            clear_hist <= 1'b1;
            fin_q      <= 1'b0;
        end else begin
            next_sync  <= {next_sync[SYNC_STAGES-2:0], Next};
            clear_sync <= {clear_sync[SYNC_STAGES-2:0], Clear};
            next_hist  <= next_sync[SYNC_STAGES-1];
            clear_hist <= clear_sync[SYNC_STAGES-1];
            fin_q      <= finished;
        end
    end

    assign next_press  = next_hist & ~next_sync[SYNC_STAGES-1];
    assign clear_press = clear_hist & ~clear_sync[SYNC_STAGES-1];
    assign capture     = finished & ~fin_q;

    always_comb begin
        state_n = state;
        idx_n   = byte_idx;
        case (state)
            IDLE: begin
                if (capture && !clear_press) begin
                    state_n = SHOW;
                    idx_n   = '0;
                end
            end
            SHOW: begin
                if (clear_press) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (capture) begin
                    idx_n = '0;
                end else if (next_press) begin
                    idx_n = (byte_idx == LAST) ? 5'd0 : byte_idx + 5'd1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // Select from the post-edge digest/index so byte and index always change together.
    always_comb begin
        digest_n = capture ? digest_in : digest_q;
        sel_lo   = DW - 8 - 8 * int'(idx_n);
        byte_sel = digest_n[sel_lo +: 8];
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            byte_idx <= '0;
            digest_q <= '0;
            valid    <= 1'b0;
            byte_out <= '0;
            leds     <= '0;
            hexU     <= BLANK;
            hexL     <= BLANK;
            hexC     <= BLANK;
            hex1     <= BLANK;
        end else begin
            state    <= state_n;
            byte_idx <= idx_n;
            digest_q <= digest_n;
            if (state_n == SHOW) begin
                valid    <= 1'b1;
                byte_out <= byte_sel;
                leds     <= byte_sel;
                hexU     <= seg7(byte_sel[7:4]);
                hexL     <= seg7(byte_sel[3:0]);
                hexC     <= seg7({3'b000, idx_n[4]});
                hex1     <= seg7(idx_n[3:0]);
            end else begin
                valid    <= 1'b0;
                byte_out <= '0;
                leds     <= '0;
                hexU     <= BLANK;
                hexL     <= BLANK;
                hexC     <= BLANK;
                hex1     <= BLANK;
            end
        end
    end

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Bench for sha256_digest_reader: directed scenarios plus random button/finished traffic,
// checked every cycle against a byte-array reference model.
module tb_sha256_digest_reader;
    localparam int S = 2;

    logic         clk, Reset, finished, Next, Clear;
    logic [255:0] digest_in;
    logic [7:0]   byte_out, leds;
    logic [4:0]   byte_idx;
    logic         valid;
    logic [6:0]   hexU, hexL, hexC, hex1;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 0;

    localparam logic [255:0] ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    sha256_digest_reader #(.SYNC_STAGES(S), .NUM_BYTES(32)) dut (
        .clk(clk), .Reset(Reset), .finished(finished), .digest_in(digest_in),
        .Next(Next), .Clear(Clear), .byte_out(byte_out), .byte_idx(byte_idx),
        .valid(valid), .leds(leds), .hexU(hexU), .hexL(hexL), .hexC(hexC), .hex1(hex1)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input int v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v & 15];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a button press takes effect S+1 edges after the pin falls.
    logic [S:0]  nh, ch;
    logic        fprev, m_shown;
    int          m_idx;
    logic [7:0]  m_dig [32];

    always @(posedge clk or negedge Reset) begin : model
        logic nxt, clr, cap;
        if (!Reset) begin
            nh <= '1; ch <= '1; fprev <= 1'b0; m_shown <= 1'b0; m_idx <= 0;
            for (int i = 0; i < 32; i++) m_dig[i] <= 8'h00;
        end else begin
            nxt = !nh[S-1] && nh[S];
            clr = !ch[S-1] && ch[S];
            cap = finished && !fprev;
            nh <= {nh[S-1:0], Next};
            ch <= {ch[S-1:0], Clear};
            fprev <= finished;
            if (cap) for (int i = 0; i < 32; i++) m_dig[i] <= digest_in[255-8*i -: 8];
            if (clr) begin
                m_shown <= 1'b0; m_idx <= 0;
            end else if (cap) begin
                m_shown <= 1'b1; m_idx <= 0;
            end else if (nxt && m_shown) begin
                m_idx <= (m_idx + 1) % 32;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [7:0] eb;
            eb = m_shown ? m_dig[m_idx] : 8'h00;
            chk("valid", 32'(valid), 32'(m_shown));
            chk("byte_idx", 32'(byte_idx), 32'(m_idx));
            chk("byte_out", 32'(byte_out), 32'(eb));
            chk("leds", 32'(leds), 32'(eb));
            chk("hexU", 32'(hexU), m_shown ? 32'(seg_ref(int'(eb) >> 4)) : 32'h7F);
            chk("hexL", 32'(hexL), m_shown ? 32'(seg_ref(int'(eb))) : 32'h7F);
            chk("hexC", 32'(hexC), m_shown ? 32'(seg_ref(m_idx >> 4)) : 32'h7F);
            chk("hex1", 32'(hex1), m_shown ? 32'(seg_ref(m_idx)) : 32'h7F);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_next(input int len);
        Next = 0; cyc(len); Next = 1; cyc(4);
    endtask

    initial begin
        Reset = 0; Next = 1; Clear = 1; finished = 0; digest_in = '0;
        #1 cmp_en = 1;
        cyc(2);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_leds", 32'(leds), 0);
        chk("rst_idx", 32'(byte_idx), 0);
        chk("rst_hexU", 32'(hexU), 32'h7F);
        chk("rst_hexC", 32'(hexC), 32'h7F);
        Reset = 1;
        cyc(10);
        chk("idle_valid", 32'(valid), 0);

        digest_in = ABC; finished = 1;
        cyc(2);
        chk("cap_valid", 32'(valid), 1);
        chk("cap_idx", 32'(byte_idx), 0);
        chk("cap_byte", 32'(byte_out), 32'hBA);
        chk("cap_leds", 32'(leds), 32'hBA);
        chk("cap_hexC", 32'(hexC), 32'h40);
        chk("cap_hex1", 32'(hex1), 32'h40);

        for (int i = 0; i < 4; i++) press_next(int'($urandom_range(1, 5)));
        chk("step_idx", 32'(byte_idx), 4);
        chk("step_byte", 32'(byte_out), 32'h8F);
        press_next(20);
        chk("hold_idx", 32'(byte_idx), 5);

        for (int i = 0; i < 26; i++) press_next(int'($urandom_range(1, 5)));
        chk("last_idx", 32'(byte_idx), 31);
        chk("last_byte", 32'(byte_out), 32'hAD);
        chk("last_hexC", 32'(hexC), 32'h79);
        chk("last_hex1", 32'(hex1), 32'h0E);
        press_next(2);
        chk("wrap_idx", 32'(byte_idx), 0);
        chk("wrap_byte", 32'(byte_out), 32'hBA);

        press_next(1);
        chk("pre_pri_idx", 32'(byte_idx), 1);
        finished = 0; digest_in = {32{8'h11}};
        cyc(1);
        Next = 0; cyc(2); finished = 1; cyc(1); Next = 1; cyc(4);
        chk("pri_nx_idx", 32'(byte_idx), 0);
        chk("pri_nx_byte", 32'(byte_out), 32'h11);

        finished = 0; digest_in = ABC;
        cyc(1);
        Clear = 0; cyc(2); finished = 1; cyc(1); Clear = 1; cyc(4);
        chk("pri_clr_valid", 32'(valid), 0);

        finished = 0; cyc(1); finished = 1; cyc(2);
        chk("recap_byte", 32'(byte_out), 32'hBA);
        for (int i = 0; i < 7; i++) press_next(int'($urandom_range(1, 5)));
        chk("mid_idx", 32'(byte_idx), 7);
        @(posedge clk); #3 Reset = 0;
        #1;
        chk("arst_valid", 32'(valid), 0);
        chk("arst_idx", 32'(byte_idx), 0);
        chk("arst_leds", 32'(leds), 0);
        chk("arst_hexU", 32'(hexU), 32'h7F);
        finished = 0;
        cyc(2); Reset = 1;
        press_next(2); press_next(3);
        chk("post_rst_valid", 32'(valid), 0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!Reset) Reset = 1;
            else if ($urandom_range(0, 999) == 0) Reset = 0;
            if ($urandom_range(0, 99) < 8) Next = ~Next;
            if (Clear && $urandom_range(0, 299) == 0) Clear = 0;
            else if (!Clear && $urandom_range(0, 2) == 0) Clear = 1;
            if ($urandom_range(0, 99) < 3) finished = ~finished;
            if (!finished) for (int w = 0; w < 8; w++) digest_in[32*w +: 32] = $urandom;
        end
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
